// File: rtl/pass_entry.sv
// Two-digit passcode entry: synchronizes and debounces raw keypad inputs, then
// collects up to two digits with clear and idle-timeout handling.
module pass_entry #(
  parameter int DEBOUNCE     = 3,
  parameter int IDLE_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] key_digit,
  input  logic       key_strobe,
  input  logic       key_clear,
  output logic [1:0] pass1,
  output logic [1:0] pass2,
  output logic       pass_ready,
  output logic [1:0] digit_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [3:0] DB_MAX    = 4'(DEBOUNCE);
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
    sat_inc = (val >= lim) ? lim : val + 4'd1;
  endfunction

  logic [1:0] digit_p0, digit_p1;
  logic       strobe_p0, strobe_p1;
  logic       clear_p0, clear_p1;

  logic [3:0] db_cnt;
  logic       pressed, pressed_q, press_evt;

  logic [1:0] state, state_nx;
  logic [1:0] pass1_nx, pass2_nx;
  logic [7:0] idle_cnt, idle_nx;
  logic       ready_nx;
  logic [1:0] cnt_nx;

  // Stage p0/p1: two-flop synchronizers on every raw input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_p0  <= 2'd0;
      digit_p1  <= 2'd0;
      strobe_p0 <= 1'b0;
      strobe_p1 <= 1'b0;
      clear_p0  <= 1'b0;
      clear_p1  <= 1'b0;
    end else begin
      digit_p0  <= key_digit;
      digit_p1  <= digit_p0;
      strobe_p0 <= key_strobe;
      strobe_p1 <= strobe_p0;
      clear_p0  <= key_clear;
      clear_p1  <= clear_p0;
    end
  end

  // Debounce: any low sample restarts the count, so short bounces never qualify
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt    <= 4'd0;
      pressed_q <= 1'b0;
    end else begin
      db_cnt    <= strobe_p1 ? sat_inc(db_cnt, DB_MAX) : 4'd0;
      pressed_q <= pressed;
    end
  end

  assign pressed   = (db_cnt == DB_MAX);
  assign press_evt = pressed & ~pressed_q;

  // Entry FSM; clear outranks both press and timeout
  always_comb begin
    state_nx = state;
    pass1_nx = pass1;
    pass2_nx = pass2;
    idle_nx  = idle_cnt;
    if (clear_p1) begin
      state_nx = EMPTY;
      pass1_nx = 2'd0;
      pass2_nx = 2'd0;
      idle_nx  = 8'd0;
    end else begin
      case (state)
        EMPTY: begin
          idle_nx = 8'd0;
          if (press_evt) begin
            state_nx = ONE;
            pass1_nx = digit_p1;
            pass2_nx = 2'd0;
          end
        end
        ONE, FULL: begin
          if (press_evt) begin
            idle_nx = 8'd0;
            if (state == ONE) begin
              state_nx = FULL;
              pass2_nx = digit_p1;
            end else begin
              state_nx = ONE;
              pass1_nx = digit_p1;
              pass2_nx = 2'd0;
            end
          end else if (idle_cnt >= IDLE_LAST) begin
            state_nx = EMPTY;
            pass1_nx = 2'd0;
            pass2_nx = 2'd0;
            idle_nx  = 8'd0;
          end else begin
            idle_nx = idle_cnt + 8'd1;
          end
        end
        default: begin
          state_nx = EMPTY;
          pass1_nx = 2'd0;
          pass2_nx = 2'd0;
          idle_nx  = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    ready_nx = (state_nx == FULL);
    case (state_nx)
      ONE:     cnt_nx = 2'd1;
      FULL:    cnt_nx = 2'd2;
      default: cnt_nx = 2'd0;
    endcase
  end

  // Outputs are registered so downstream compares see glitch-free values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      pass1      <= 2'd0;
      pass2      <= 2'd0;
      idle_cnt   <= 8'd0;
      pass_ready <= 1'b0;
      digit_cnt  <= 2'd0;
    end else begin
      state      <= state_nx;
      pass1      <= pass1_nx;
      pass2      <= pass2_nx;
      idle_cnt   <= idle_nx;
      pass_ready <= ready_nx;
      digit_cnt  <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_pass_entry.sv
// Directed self-checking bench for pass_entry (DEBOUNCE=3, IDLE_TIMEOUT=30).
module tb_pass_entry;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] key_digit;
  logic       key_strobe;
  logic       key_clear;
  logic [1:0] pass1, pass2, digit_cnt;
  logic       pass_ready;

  int checks = 0;
  int errors = 0;

  pass_entry #(.DEBOUNCE(3), .IDLE_TIMEOUT(30)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_digit  (key_digit),
    .key_strobe (key_strobe),
    .key_clear  (key_clear),
    .pass1      (pass1),
    .pass2      (pass2),
    .pass_ready (pass_ready),
    .digit_cnt  (digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int p1, input int p2, input int rdy, input int cnt);
    chk({tag, ".pass1"}, int'(pass1), p1);
    chk({tag, ".pass2"}, int'(pass2), p2);
    chk({tag, ".ready"}, int'(pass_ready), rdy);
    chk({tag, ".cnt"}, int'(digit_cnt), cnt);
  endtask

  initial begin
    reset_n    = 1'b1;
    key_digit  = 2'd0;
    key_strobe = 1'b0;
    key_clear  = 1'b0;
    #2 reset_n = 1'b0;
    #20;
    chk_all("reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    tick(3);
    chk_all("idle_after_reset", 0, 0, 0, 0);

    // Steady press: capture lands on edge 6
    key_digit  = 2'd1;
    key_strobe = 1'b1;
    tick(5);
    chk_all("edge5", 0, 0, 0, 0);
    tick(1);
    chk_all("edge6", 1, 0, 0, 1);
    tick(4);
    chk_all("held_one_event", 1, 0, 0, 1);
    key_strobe = 1'b0;
    tick(10);
    key_digit  = 2'd2;
    key_strobe = 1'b1;
    tick(10);
    chk_all("second_digit", 1, 2, 1, 2);

    // Third press while FULL restarts the entry
    key_strobe = 1'b0;
    tick(4);
    key_digit  = 2'd3;
    key_strobe = 1'b1;
    tick(8);
    chk_all("restart", 3, 0, 0, 1);

    // Clear from ONE
    key_strobe = 1'b0;
    key_clear  = 1'b1;
    tick(4);
    chk_all("clear", 0, 0, 0, 0);
    key_clear = 1'b0;
    tick(3);

    // Idle timeout exactly 30 edges after the capture edge
    key_digit  = 2'd1;
    key_strobe = 1'b1;
    tick(6);
    chk_all("to_capture", 1, 0, 0, 1);
    key_strobe = 1'b0;
    tick(29);
    chk_all("to_before", 1, 0, 0, 1);
    tick(1);
    chk_all("to_expired", 0, 0, 0, 0);

    // Clear and press meet on the same edge in ONE
    key_digit  = 2'd2;
    key_strobe = 1'b1;
    tick(6);
    chk_all("one_for_clear", 2, 0, 0, 1);
    key_strobe = 1'b0;
    tick(4);
    key_digit  = 2'd3;
    key_strobe = 1'b1;
    tick(3);
    key_clear = 1'b1;
    tick(3);
    chk_all("clear_vs_press", 0, 0, 0, 0);
    tick(3);
    key_clear = 1'b0;
    tick(6);
    chk_all("press_not_deferred", 0, 0, 0, 0);
    key_strobe = 1'b0;
    tick(4);

    // Bounce: high 2 / low 1 never satisfies the debounce count
    key_digit = 2'd1;
    for (int i = 0; i < 21; i++) begin
      key_strobe = ((i % 3) != 2);
      tick(1);
    end
    chk_all("bounce_none", 0, 0, 0, 0);
    key_strobe = 1'b1;
    tick(10);
    chk_all("bounce_then_steady", 1, 0, 0, 1);

    // Reach FULL, then async reset between edges with strobe still held
    key_strobe = 1'b0;
    tick(4);
    key_digit  = 2'd2;
    key_strobe = 1'b1;
    tick(8);
    chk_all("full_before_reset", 1, 2, 1, 2);
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0);
    #1 reset_n = 1'b1;
    tick(5);
    chk_all("post_reset_edge5", 0, 0, 0, 0);
    tick(1);
    chk_all("post_reset_edge6", 2, 0, 0, 1);
    tick(6);
    chk_all("post_reset_single", 2, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pass_entry.md
PASS_ENTRY -- requirements
Module: pass_entry

Interface
REQ-001 Parameter DEBOUNCE, default 3: consecutive synchronized-high samples needed to accept a key press (range 1..15).
REQ-002 Parameter IDLE_TIMEOUT, default 30: idle clock cycles after the last accepted press before the entry is discarded (range 2..255).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 key_digit  input  2  raw digit switches (asynchronous to clk), read at press acceptance.
REQ-006 key_strobe  input  1  raw enter push-button (asynchronous, bouncing), high = pressed.
REQ-007 key_clear  input  1  raw clear button (asynchronous), high = clear.
REQ-008 pass1  output  2  first captured digit, registered.
REQ-009 pass2  output  2  second captured digit, registered.
REQ-010 pass_ready  output  1  high while both digits are held (state FULL), registered.
REQ-011 digit_cnt  output  2  number of digits held (0, 1, 2), registered.

Function
REQ-012 key_digit, key_strobe and key_clear SHALL each pass through a two-flop synchronizer before any use.
REQ-013 The debounce counter SHALL increment, saturating at DEBOUNCE, on each edge the synchronized strobe is high, and clear to 0 on any edge it is low.
REQ-014 The internal level "pressed" SHALL be high exactly when the debounce counter equals DEBOUNCE; a press event is a single-cycle pulse on the 0->1 transition of "pressed" (one event per press, however long it is held).
REQ-015 Timing: key_strobe rising before edge 1 and held steady SHALL update pass1 on edge 3+DEBOUNCE (edge 6 at DEBOUNCE=3); a high run shorter than DEBOUNCE synchronized samples SHALL produce no event.
REQ-016 States: EMPTY (digit_cnt=0), ONE (digit_cnt=1), FULL (digit_cnt=2, pass_ready=1).
REQ-017 EMPTY + press event -> capture synchronized key_digit into pass1, pass2=0, go to ONE.
REQ-018 ONE + press event -> capture into pass2, go to FULL; pass1 unchanged.
REQ-019 FULL + press event -> restart: capture into pass1, pass2=0, go to ONE.
REQ-020 The idle counter SHALL reset to 0 on every accepted press and on entry to EMPTY, and increment on every cycle spent in ONE or FULL without a press.
REQ-021 In ONE or FULL, when the idle counter reaches IDLE_TIMEOUT-1 and no press occurs, the next edge SHALL go to EMPTY with pass1=pass2=0.
REQ-022 A synchronized key_clear high SHALL force EMPTY, pass1=pass2=0, on the next edge from any state, and SHALL take priority over a simultaneous press event or timeout.
REQ-023 While key_clear is held high, press events SHALL be discarded (not deferred).
REQ-024 pass1 and pass2 SHALL hold steady between captures; outputs never glitch, as they feed combinational compares downstream.
REQ-025 In EMPTY the idle counter SHALL hold at 0; no timeout action SHALL occur in EMPTY.
REQ-026 Unreachable state encodings SHALL return to EMPTY on the next edge with all outputs cleared.

Reset
REQ-027 When reset_n is low: state=EMPTY, pass1=0, pass2=0, pass_ready=0, digit_cnt=0, with the synchronizers, debounce counter, "pressed" and idle counter all cleared, taking effect immediately without waiting for a clock edge.
REQ-028 Reset asserted mid-entry or mid-press SHALL discard the partial entry; after release, a strobe still held high SHALL produce exactly one event once DEBOUNCE synchronized samples are seen.

Verification
REQ-029 DEBOUNCE=3: key_digit=1, strobe high 10 cycles, low 10, then key_digit=2, strobe high 10 -> pass1=1 at edge 6, then pass2=2, pass_ready=1, digit_cnt=2.
REQ-030 Bounce: strobe toggling high 2 / low 1 for 20 cycles, then steady high -> exactly one event, pass1 captured once, digit_cnt=1.
REQ-031 Timeout: one digit entered, no further input -> EMPTY, pass1=0, digit_cnt=0 exactly IDLE_TIMEOUT cycles after the capture edge.
REQ-032 Clear and press events arrive on the same cycle in ONE -> EMPTY, pass1=pass2=0, no capture.
REQ-033 Third press while FULL with key_digit=3 -> pass1=3, pass2=0, pass_ready=0, digit_cnt=1.
REQ-034 reset_n pulsed low between clock edges while FULL -> all outputs 0 immediately, with no clock edge required.
